// File: rtl/ccff_cfg_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
package ccff_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      VERIFY,
      DRAIN,
      DONE,
      ERROR
   } state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // CRC-16-CCITT, one bit per call, MSB-feedback form.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word buffer for the chain loader: accepts a CFG_W word when empty
// and hands its bits out LSB-first, one per take_i.
module ccff_word_serializer #(
   parameter int CFG_W = 32
) (
   input  logic             prog_clk,
   input  logic             pReset_n,
   input  logic             active_i,
   input  logic [CFG_W-1:0] cfg_data_i,
   input  logic             cfg_valid_i,
   input  logic             take_i,
   input  logic             flush_i,
   output logic             cfg_ready_o,
   output logic             bit_o,
   output logic             has_bit_o
);

   localparam int IDX_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

   logic [CFG_W-1:0] buf_q;
   logic [IDX_W-1:0] idx_q;
   logic             empty_q;

   assign cfg_ready_o = active_i && empty_q;
   assign has_bit_o   = !empty_q;
   assign bit_o       = buf_q[idx_q];

   // Flush wins so the tail of a word past the end of a pass is dropped.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         buf_q   <= '0;
         idx_q   <= '0;
         empty_q <= 1'b1;
      end else if (flush_i) begin
         idx_q   <= '0;
         empty_q <= 1'b1;
      end else if (cfg_ready_o && cfg_valid_i) begin
         buf_q   <= cfg_data_i;
         idx_q   <= '0;
         empty_q <= 1'b0;
      end else if (take_i) begin
         if (idx_q == IDX_W'(CFG_W - 1)) begin
            idx_q   <= '0;
            empty_q <= 1'b1;
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words onto ccff_head and
// optionally re-shifts the stream, CRC-checking what emerges on ccff_tail.
module ccff_chain_loader
   import ccff_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 46,
   parameter int CFG_W     = 32,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic             prog_clk,
   input  logic             pReset_n,
   input  logic             start,
   input  logic             verify_en,
   input  logic [CFG_W-1:0] cfg_data,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             ccff_head,
   input  logic             ccff_tail,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic             error
);

   state_e           state_q;
   logic             verify_q;
   logic             head_q;
   logic             shift_q;
   logic             vshift_q;
   logic             done_q;
   logic             error_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [15:0]      crc_in_q;
   logic [15:0]      crc_out_q;
   logic [15:0]      crc_out_d;

   logic active;
   logic has_bit;
   logic ser_bit;
   logic take;
   logic last_bit;
   logic start_ok;

   assign active   = (state_q == LOAD) || (state_q == VERIFY);
   assign take     = active && has_bit;
   assign last_bit = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
   assign start_ok = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

   // vshift_q marks edges where the chain captures a pass-2 bit; the value on
   // ccff_tail just before such an edge is the matching pass-1 bit.
   assign crc_out_d = vshift_q ? crc16_step(crc_out_q, ccff_tail) : crc_out_q;

   assign ccff_head = head_q;
   assign shift_en  = shift_q;
   assign busy      = active || (state_q == DRAIN);
   assign done      = done_q;
   assign error     = error_q;

   ccff_word_serializer #(
      .CFG_W(CFG_W)
   ) u_ser (
      .prog_clk    (prog_clk),
      .pReset_n    (pReset_n),
      .active_i    (active),
      .cfg_data_i  (cfg_data),
      .cfg_valid_i (cfg_valid),
      .take_i      (take),
      .flush_i     (take && last_bit),
      .cfg_ready_o (cfg_ready),
      .bit_o       (ser_bit),
      .has_bit_o   (has_bit)
   );

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q   <= IDLE;
         verify_q  <= 1'b0;
         head_q    <= 1'b0;
         shift_q   <= 1'b0;
         vshift_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         bit_cnt_q <= '0;
         crc_in_q  <= CRC16_INIT;
         crc_out_q <= CRC16_INIT;
      end else begin
         done_q    <= 1'b0;
         shift_q   <= 1'b0;
         vshift_q  <= 1'b0;
         crc_out_q <= crc_out_d;
         case (state_q)
            IDLE, DONE, ERROR: begin
               if (start_ok) begin
                  state_q   <= LOAD;
                  verify_q  <= verify_en;
                  bit_cnt_q <= '0;
                  crc_in_q  <= CRC16_INIT;
                  crc_out_q <= CRC16_INIT;
                  error_q   <= 1'b0;
               end
            end
            LOAD, VERIFY: begin
               if (take) begin
                  head_q   <= ser_bit;
                  shift_q  <= 1'b1;
                  vshift_q <= (state_q == VERIFY);
                  if (state_q == LOAD) begin
                     crc_in_q <= crc16_step(crc_in_q, ser_bit);
                  end
                  if (last_bit) begin
                     bit_cnt_q <= '0;
                     state_q   <= ((state_q == LOAD) && verify_q) ? VERIFY : DRAIN;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (!verify_q || (crc_out_d == crc_in_q)) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  error_q <= 1'b1;
                  state_q <= ERROR;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural chain model plus a queue of
// expected ccff_head bits filled on each word handshake.
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 46;
   localparam int CFG_W     = 32;
   localparam logic [31:0] W1 = 32'hA5A5_F00F;
   localparam logic [31:0] W2 = 32'h0000_3C5A;

   logic             prog_clk  = 1'b0;
   logic             pReset_n  = 1'b0;
   logic             start     = 1'b0;
   logic             verify_en = 1'b0;
   logic [CFG_W-1:0] cfg_data  = '0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic             ccff_head;
   logic             ccff_tail;
   logic             shift_en;
   logic             busy;
   logic             done;
   logic             error;

   logic [CHAIN_LEN-1:0] chain = '0;
   logic [CHAIN_LEN-1:0] chainNxt;
   logic [CHAIN_LEN-1:0] expChain;
   logic [63:0]          cat;
   logic [15:0]          crcModel;
   logic                 faultEn = 1'b0;
   logic                 expQ[$];

   int checks     = 0;
   int failures   = 0;
   int shiftCount = 0;
   int cyc        = 0;
   int passRemaining;
   int hsCyc;
   int endCyc;
   int base;
   bit firstHs;
   bit sawDone;
   bit sawErr;

   ccff_chain_loader #(
      .CHAIN_LEN(CHAIN_LEN),
      .CFG_W    (CFG_W)
   ) dut (
      .prog_clk  (prog_clk),
      .pReset_n  (pReset_n),
      .start     (start),
      .verify_en (verify_en),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .shift_en  (shift_en),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: shifts toward the tail; optional stuck-at-1 on FF 17.
   assign ccff_tail = chain[CHAIN_LEN-1];
   always_comb begin
      chainNxt = {chain[CHAIN_LEN-2:0], ccff_head};
      if (faultEn) chainNxt[17] = 1'b1;
   end
   always @(posedge prog_clk) begin
      cyc <= cyc + 1;
      if (shift_en) chain <= chainNxt;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   always @(negedge prog_clk) begin
      if (shift_en) begin
         shiftCount++;
         if (expQ.size() == 0) checkOutput("head_unexpected_shift", 1, 0);
         else checkOutput("head_bit", ccff_head, expQ.pop_front());
      end
   end

   function automatic logic [15:0] tbCrcStep(input logic [15:0] c, input logic b);
      logic [15:0] r;
      r = c << 1;
      if (c[15] != b) r = r ^ 16'h1021;
      return r;
   endfunction

   task automatic pulseStart(input logic v);
      start = 1'b1;
      verify_en = v;
      @(negedge prog_clk);
      start = 1'b0;
   endtask

   task automatic startLoad(input logic v);
      passRemaining = CHAIN_LEN;
      firstHs = 1'b1;
      pulseStart(v);
   endtask

   task automatic applyStimulus(input logic [31:0] w);
      int n;
      int nb;
      n = 0;
      cfg_data = w;
      cfg_valid = 1'b1;
      while (!cfg_ready && n < 300) begin
         @(negedge prog_clk);
         n++;
      end
      checkOutput("handshake_ready", cfg_ready, 1);
      if (!cfg_ready) begin
         cfg_valid = 1'b0;
         return;
      end
      nb = (passRemaining < CFG_W) ? passRemaining : CFG_W;
      for (int i = 0; i < nb; i++) expQ.push_back(w[i]);
      passRemaining -= nb;
      if (passRemaining == 0) passRemaining = CHAIN_LEN;
      @(posedge prog_clk);
      #1;
      if (firstHs) begin
         hsCyc = cyc;
         firstHs = 1'b0;
      end
      @(negedge prog_clk);
      cfg_valid = 1'b0;
   endtask

   task automatic stallCycles(input int n);
      int k;
      int snap;
      k = 0;
      while (!cfg_ready && k < 300) begin
         @(negedge prog_clk);
         k++;
      end
      checkOutput("stall_ready", cfg_ready, 1);
      @(negedge prog_clk);
      snap = shiftCount;
      for (int i = 0; i < n; i++) begin
         checkOutput("stall_shift_en", shift_en, 0);
         checkOutput("stall_bit_cnt", dut.bit_cnt_q, 32);
         @(negedge prog_clk);
      end
      checkOutput("stall_frozen", shiftCount, snap);
   endtask

   task automatic waitEnd();
      int k;
      k = 0;
      while (!done && !error && k < 1000) begin
         @(negedge prog_clk);
         k++;
      end
      endCyc = cyc;
      sawDone = done;
      sawErr = error;
      if (!done && !error) checkOutput("end_timeout", 0, 1);
      if (done) begin
         @(negedge prog_clk);
         checkOutput("done_pulse_width", done, 0);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_cfg_ready"}, cfg_ready, 0);
      checkOutput({tag, "_ccff_head"}, ccff_head, 0);
      checkOutput({tag, "_shift_en"}, shift_en, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_error"}, error, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cat = {W2, W1};
      crcModel = 16'hFFFF;
      for (int k = 0; k < CHAIN_LEN; k++) begin
         expChain[CHAIN_LEN-1-k] = cat[k];
         crcModel = tbCrcStep(crcModel, cat[k]);
      end

      repeat (3) @(negedge prog_clk);
      checkIdleOutputs("reset");
      pReset_n = 1'b1;

      // Words offered while idle must not be accepted.
      cfg_data = W1;
      cfg_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge prog_clk);
         checkOutput("idle_cfg_ready", cfg_ready, 0);
         checkOutput("idle_shift_en", shift_en, 0);
      end
      cfg_valid = 1'b0;

      base = shiftCount;
      startLoad(1'b0);
      applyStimulus(W1);
      applyStimulus(W2);
      waitEnd();
      checkOutput("plain_done", sawDone, 1);
      checkOutput("plain_error", sawErr, 0);
      checkOutput("plain_latency", endCyc - hsCyc, 48);
      checkOutput("plain_shifts", shiftCount - base, 46);
      checkOutput("plain_chain", chain, expChain);
      checkOutput("plain_queue_left", expQ.size(), 0);
      cfg_valid = 1'b1;
      @(negedge prog_clk);
      checkOutput("done_cfg_ready", cfg_ready, 0);
      checkOutput("done_busy", busy, 0);
      cfg_valid = 1'b0;

      base = shiftCount;
      startLoad(1'b1);
      applyStimulus(W1);
      applyStimulus(W2);
      applyStimulus(W1);
      applyStimulus(W2);
      waitEnd();
      checkOutput("verify_done", sawDone, 1);
      checkOutput("verify_error", sawErr, 0);
      checkOutput("verify_shifts", shiftCount - base, 92);
      checkOutput("verify_crc_in", dut.crc_in_q, crcModel);
      checkOutput("verify_crc_out", dut.crc_out_q, crcModel);
      checkOutput("verify_chain", chain, expChain);

      faultEn = 1'b1;
      startLoad(1'b1);
      applyStimulus(W1);
      applyStimulus(W2);
      applyStimulus(W1);
      applyStimulus(W2);
      waitEnd();
      checkOutput("fault_error", sawErr, 1);
      checkOutput("fault_no_done", sawDone, 0);
      repeat (3) @(negedge prog_clk);
      checkOutput("fault_error_sticky", error, 1);
      checkOutput("fault_busy", busy, 0);
      faultEn = 1'b0;
      startLoad(1'b0);
      checkOutput("fault_error_cleared", error, 0);
      applyStimulus(W1);
      applyStimulus(W2);
      waitEnd();
      checkOutput("reload_done", sawDone, 1);
      checkOutput("reload_chain", chain, expChain);

      base = shiftCount;
      startLoad(1'b1);
      applyStimulus(W1);
      stallCycles(5);
      applyStimulus(W2);
      applyStimulus(W1);
      stallCycles(5);
      applyStimulus(W2);
      waitEnd();
      checkOutput("stall_done", sawDone, 1);
      checkOutput("stall_error", sawErr, 0);
      checkOutput("stall_shifts", shiftCount - base, 92);
      checkOutput("stall_chain", chain, expChain);

      // Reset in the middle of a pass.
      base = shiftCount;
      startLoad(1'b0);
      applyStimulus(W1);
      for (int k = 0; k < 200 && (shiftCount - base) < 20; k++) @(negedge prog_clk);
      checkOutput("midreset_reached", ((shiftCount - base) >= 20) ? 1 : 0, 1);
      #2;
      pReset_n = 1'b0;
      #1;
      checkIdleOutputs("midreset");
      expQ.delete();
      @(negedge prog_clk);
      pReset_n = 1'b1;
      @(negedge prog_clk);
      base = shiftCount;
      startLoad(1'b0);
      applyStimulus(W1);
      applyStimulus(W2);
      waitEnd();
      checkOutput("after_reset_done", sawDone, 1);
      checkOutput("after_reset_latency", endCyc - hsCyc, 48);
      checkOutput("after_reset_shifts", shiftCount - base, 46);
      checkOutput("after_reset_chain", chain, expChain);

      // start while busy must not restart or add a verify pass.
      base = shiftCount;
      startLoad(1'b0);
      applyStimulus(W1);
      for (int k = 0; k < 200 && (shiftCount - base) < 10; k++) @(negedge prog_clk);
      pulseStart(1'b1);
      checkOutput("busy_start_busy", busy, 1);
      applyStimulus(W2);
      waitEnd();
      checkOutput("busy_start_done", sawDone, 1);
      checkOutput("busy_start_latency", endCyc - hsCyc, 48);
      checkOutput("busy_start_shifts", shiftCount - base, 46);
      checkOutput("busy_start_chain", chain, expChain);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
